// File: rtl/fpu_flags_pkg.sv
// fpu_flags_pkg: shared flag layout and buffer entry type for the FPU flags collector.
package fpu_flags_pkg;
  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;
  localparam int ENTRY_TAG_W = 5;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;
  typedef struct packed {
    logic [63:0] result;
    logic [ENTRY_TAG_W-1:0] tag;
    fflags_t flags;
  } entry_t;
endpackage

// File: rtl/fpu_flags_collector_if.sv
// fpu_flags_collector_if: exception-stage input, writeback output and CSR access bundle.
interface fpu_flags_collector_if #(parameter int TAG_W = 5);
  logic in_valid;
  logic in_ready;
  logic [63:0] in_result;
  logic [TAG_W-1:0] in_tag;
  logic in_invalid;
  logic in_div_zero;
  logic in_overflow;
  logic in_underflow;
  logic in_inexact;
  logic out_valid;
  logic out_ready;
  logic [63:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic [4:0] out_flags;
  logic flush;
  logic csr_we;
  logic [4:0] csr_wdata;
  logic [4:0] fflags;
  modport master (
    output in_valid, in_result, in_tag, in_invalid, in_div_zero, in_overflow, in_underflow, in_inexact,
    output out_ready, flush, csr_we, csr_wdata,
    input in_ready, out_valid, out_result, out_tag, out_flags, fflags
  );
  modport slave (
    input in_valid, in_result, in_tag, in_invalid, in_div_zero, in_overflow, in_underflow, in_inexact,
    input out_ready, flush, csr_we, csr_wdata,
    output in_ready, out_valid, out_result, out_tag, out_flags, fflags
  );
endinterface

// File: rtl/fpu_flags_fifo.sv
// fpu_flags_fifo: in-order circular buffer with push/pop and whole-buffer flush.
module fpu_flags_fifo #(
  parameter int DEPTH = 2,
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  T din,
  output T dout,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
  // flush discards everything left after a same-cycle pop, so rd simply snaps to wr
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= wr;
      count <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = empty ? '0 : mem[rd];
endmodule

// File: rtl/fpu_flags_collector.sv
// fpu_flags_collector: buffers FPU results for writeback and accrues IEEE flags on retire.
module fpu_flags_collector
  import fpu_flags_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = ENTRY_TAG_W
) (
  input logic clk,
  input logic rst,
  fpu_flags_collector_if.slave bus
);
  logic full, empty, in_fire, out_fire;
  logic [4:0] in_flags;
  logic [$clog2(DEPTH):0] count;
  entry_t din, head;
  always_comb begin
    in_flags = '0;
    in_flags[FFLAG_NV] = bus.in_invalid;
    in_flags[FFLAG_DZ] = bus.in_div_zero;
    in_flags[FFLAG_OF] = bus.in_overflow;
    in_flags[FFLAG_UF] = bus.in_underflow;
    in_flags[FFLAG_NX] = bus.in_inexact;
  end
  assign din = '{result: bus.in_result, tag: bus.in_tag, flags: fflags_t'(in_flags)};
  // in_ready depends only on registered count, never on out_ready
  assign bus.in_ready = !full;
  assign in_fire = bus.in_valid && !full;
  assign bus.out_valid = !empty;
  assign out_fire = !empty && bus.out_ready;
  assign bus.out_result = head.result;
  assign bus.out_tag = head.tag;
  assign bus.out_flags = head.flags;
  fpu_flags_fifo #(.DEPTH(DEPTH), .T(entry_t)) fifo (
    .clk(clk),
    .rst(rst),
    .push(in_fire),
    .pop(out_fire),
    .flush(bus.flush),
    .din(din),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.fflags <= '0;
    else bus.fflags <= (bus.csr_we ? bus.csr_wdata : bus.fflags) | (out_fire ? bus.out_flags : 5'b0);
endmodule

// File: doc/fpu_flags_collector.md
Name: fpu_flags_collector

Overview:
Retirement-side consumer of the FPU exception stage. It accepts each completed result together with its per-operation IEEE flags. Results are held in a small in-order buffer and handed to writeback with a valid/ready handshake. The sticky 5-bit accrued-flags register is updated only when a result actually retires, so flushed operations never pollute it. It sits between the exception stage and the register-file/CSR writeback port.

Parameters:
DEPTH, 2, buffer entries; power of two, >= 2
TAG_W, 5, width of destination/transaction tag carried with each result

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  result+flags presented by exception stage
in_ready  out  1  buffer can accept
in_result  in  64  double-precision result
in_tag  in  TAG_W  destination tag
in_invalid  in  1  NV flag
in_div_zero  in  1  DZ flag
in_overflow  in  1  OF flag
in_underflow  in  1  UF flag
in_inexact  in  1  NX flag
out_valid  out  1  head entry valid
out_ready  in  1  writeback accepts
out_result  out  64  head result
out_tag  out  TAG_W  head tag
out_flags  out  5  head per-op flags {NV,DZ,OF,UF,NX}, bit4=NV
flush  in  1  discard all buffered, unretired entries
csr_we  in  1  software write of accrued flags
csr_wdata  in  5  write value
fflags  out  5  sticky accrued flags, same bit order

Behaviour:
- Reset (async, active-high): buffer empty, read/write pointers 0, count 0, out_valid=0, out_result=0, out_tag=0, out_flags=0, fflags=0, in_ready=1 once reset is released.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- in_ready = (count != DEPTH). It comes from registered state only, with no combinational path from out_ready. When full, a same-cycle retire does not admit a new entry.
- Latency: an entry written on edge N is visible at out_* after edge N. Minimum in_fire-to-out_valid latency is 1 cycle; there is no bypass.
- Storage is a circular buffer indexed by log2(DEPTH)-bit pointers that wrap naturally. count is a (log2(DEPTH)+1)-bit register.
- Count update: +1 on in_fire only, -1 on out_fire only, unchanged when both fire.
- out_* reflects the head entry combinationally from storage. When empty, out_valid=0 and the data outputs are don't-care; they are driven as 0.
- The head entry stays stable while out_valid & !out_ready.
- Accrued-flags update: fflags_next = (csr_we ? csr_wdata : fflags) | (out_fire ? out_flags : 0). The CSR write and a same-cycle retire therefore merge, and the retire's flags are never lost.
- flush, evaluated at the clock edge:
  - An out_fire in the flush cycle completes: its flags accrue and the writeback has already sampled it.
  - After that, all remaining entries are discarded: count=0, read pointer = write pointer.
  - An in_fire in the flush cycle is dropped.
  - in_ready stays as computed before the flush; it is 1 again the following cycle.
  - fflags is otherwise untouched by flush.
- Reset asserted mid-operation clears everything immediately (asynchronously). Entries and accrued flags are lost.
- Flags are taken as-is; no consistency checking between flags and result (e.g. NaN vs NV).

Decomposition:
- Package fpu_flags_pkg:
  - Struct fflags_t (nv, dz, of, uf, nx; nv at MSB).
  - Bit-index constants FFLAG_NV=4, FFLAG_DZ=3, FFLAG_OF=2, FFLAG_UF=1, FFLAG_NX=0.
  - Entry struct {result[63:0], tag, fflags_t}.
- One sub-module, fpu_flags_fifo: parameterised circular buffer with push/pop/flush, count and full/empty. The top level holds the handshake glue and the fflags register.

Test Plan:
- Single op: in_result=0x7FF0_0000_0000_0000, tag=3, OF=NX=1, out_ready=1 -> out_valid 1 cycle later with out_flags=5'b00101, tag=3; fflags=5'b00101 the cycle after retire.
- Backpressure: out_ready=0, push 3 entries -> in_ready=0 after 2 (DEPTH=2); the 3rd is held by the producer. Release out_ready -> outputs in order, tags 1,2, then the 3rd accepted.
- Simultaneous push/pop at count=1 -> count stays 1, order preserved, no entry lost or duplicated over 20 back-to-back ops with wrap-around.
- CSR collision: fflags=5'b10000, csr_we with csr_wdata=0 in the same cycle as a retire with flags=5'b00001 -> fflags=5'b00001.
- Flush: 2 entries buffered (NV set, UF set), out_ready=0, flush=1 -> next cycle out_valid=0, in_ready=1, fflags unchanged. Repeat with out_ready=1 -> only the head's flags accrue.
- Async reset mid-stream: assert rst between edges with 2 entries buffered and fflags=5'b11111 -> out_valid=0 and fflags=0 immediately, without waiting for a clock edge.
